// File: rtl/fixmul_iter_pkg.sv
// Shared definitions for the iterative fixed-point multiplier and its neighbours
// (ALU, Mandelbrot controller): default Q16.16 format and sequencer states.
package fixmul_iter_pkg;

   localparam int unsigned FIXMUL_N    = 32;
   localparam int unsigned FIXMUL_FRAC = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } fixmul_state_t;

endpackage

// File: rtl/fixmul_iter.sv
// Multi-cycle signed fixed-point multiplier: radix-2 shift-add on magnitudes,
// then truncation toward zero, sign restore and saturation.
module fixmul_iter
   import fixmul_iter_pkg::*;
#(
   parameter int unsigned N    = FIXMUL_N,
   parameter int unsigned FRAC = FIXMUL_FRAC
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] p,
   output logic         ovf
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
   // Magnitude limits: 2^(N-1)-1 for positive results, 2^(N-1) for negative ones.
   localparam logic [2*N-1:0] POS_LIM  = {{(N + 1){1'b0}}, {(N - 1){1'b1}}};
   localparam logic [2*N-1:0] NEG_LIM  = {{N{1'b0}}, 1'b1, {(N - 1){1'b0}}};

   fixmul_state_t state, state_nxt;

   logic           neg;
   logic [N-1:0]   ma;
   logic [N-1:0]   mb;
   logic [2*N-1:0] acc;
   logic [CW-1:0]  cnt;

   logic [2*N-1:0] t;
   logic [N-1:0]   fix_p;
   logic           fix_ovf;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      t = acc >> FRAC;
      if (!neg) begin
         fix_ovf = (t > POS_LIM);
         fix_p   = fix_ovf ? POS_LIM[N-1:0] : t[N-1:0];
      end else begin
         fix_ovf = (t > NEG_LIM);
         fix_p   = fix_ovf ? NEG_LIM[N-1:0] : -t[N-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         neg <= 1'b0;
         ma  <= '0;
         mb  <= '0;
         acc <= '0;
         cnt <= '0;
         p   <= '0;
         ovf <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  neg <= a[N-1] ^ b[N-1];
                  ma  <= a[N-1] ? -a : a;
                  mb  <= b[N-1] ? -b : b;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            RUN: begin
               if (mb[cnt]) begin
                  acc <= acc + ({{N{1'b0}}, ma} << cnt);
               end
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               p   <= fix_p;
               ovf <= fix_ovf;
            end
            DONE: ;
         endcase
      end
   end

endmodule

// File: doc/fixmul_iter.md
Name: fixmul_iter

Overview:
- Multi-cycle signed fixed-point multiplier (default Q16.16) for the Mandelbrot iteration (z^2, x*y terms).
- Sits directly upstream of the 32-bit ALU. Its product p is muxed onto the ALU B operand, and the ALU then does the add/subtract/compare steps.
- Radix-2 shift-add on operand magnitudes, followed by sign fix-up and saturation.
- Uses start/busy/done handshake so the controller can stall while a product is in flight.

Parameters:
- N, 32, operand/result width in bits (two's complement).
- FRAC, 16, number of fractional bits; must satisfy 0 <= FRAC < N.

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a multiply; sampled only in IDLE.
- a, input, N, multiplicand, signed fixed-point; captured on the accepted start edge.
- b, input, N, multiplier, signed fixed-point; captured on the accepted start edge.
- busy, output, 1, high from the cycle after an accepted start through the done cycle inclusive.
- done, output, 1, one-cycle pulse when p/ovf are valid.
- p, output, N, product, signed fixed-point (same format as a/b).
- ovf, output, 1, product exceeded range and p was saturated.

Behaviour:
- Reset (async, reset_n=0) forces all of the following at once, mid-operation included:
  - state=IDLE, busy=0, done=0, p=0, ovf=0;
  - internal accumulator, counter and sign register = 0.
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- States and transitions:
  - IDLE -> RUN on start=1. Same edge latches:
    - neg = a[N-1]^b[N-1];
    - ma = |a| and mb = |b| as N-bit unsigned (|-2^(N-1)| = 2^(N-1) is representable);
    - acc(2N bits) = 0, cnt = 0.
  - RUN:
    - each cycle, if mb[cnt]=1 then acc += ma<<cnt; cnt++.
    - After N RUN cycles (cnt=N-1 processed) -> FIX.
  - FIX:
    - T = acc>>FRAC (truncation of the magnitude, so the final rounding is toward zero for both signs).
    - Positive (neg=0): ovf = (T > 2^(N-1)-1); p = ovf ? 2^(N-1)-1 : T[N-1:0].
    - Negative (neg=1): ovf = (T > 2^(N-1)); p = ovf ? -2^(N-1) : -T[N-1:0] (N-bit two's complement).
    - -> DONE.
  - DONE: done=1 for exactly this cycle -> IDLE.
- Latency: start sampled at edge E0; done=1 in the cycle following edge E0+N+1 (N+2 edges total; 34 at N=32).
- busy=1 in RUN, FIX and DONE; busy=0 in IDLE.
- p/ovf are updated only on the FIX->DONE edge and held until the next FIX; they are stable while busy and after done.
- start asserted while busy=1 is ignored; no queuing.
- start asserted in the DONE cycle is ignored; it is accepted on the following IDLE cycle.
- a/b may change freely after the start edge; they have no effect until the next accepted start.
- A zero operand still takes the full latency; the result is p=0, ovf=0.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, RUN, FIX, DONE);
  - default N=32 and FRAC=16, shared with the ALU and the Mandelbrot controller.
- No sub-module needed. A small combinational abs/negate helper (twos_abs) is natural if the controller needs it too; otherwise keep it inline.

Test Plan:
- Basic product: a=0x00018000 (1.5), b=0x00020000 (2.0), start 1 cycle.
  - Required: done exactly 34 edges after start, p=0x00030000, ovf=0, busy high for 34 cycles.
- Negative product: a=0xFFFE8000 (-1.5), b=0x00020000 (2.0).
  - Required: p=0xFFFD0000, ovf=0.
  - Repeat with both operands negative: p=0x00030000.
- Saturation: a=b=0x01000000 (256.0).
  - Required: p=0x7FFFFFFF, ovf=1.
  - Repeat with a=0xFF000000 (-256.0): p=0x80000000, ovf=1.
- Boundary, truncation toward zero:
  - a=0x00000001, b=0x00008000 -> p=0x00000000.
  - a=0xFFFFFFFF, b=0x00008000 -> p=0x00000000.
  - a=0x80000000, b=0x00010000 -> p=0x80000000, ovf=0 (most negative, no overflow).
- Handshake:
  - start pulsed again at cycles 5 and 33 (busy) -> ignored, exactly one done.
  - start held high continuously -> back-to-back products, done every 35 cycles.
  - Changing a/b mid-RUN does not alter p.
- Reset mid-operation: drop reset_n at cycle 10 of RUN, asynchronously, between edges.
  - Required: busy/done/p/ovf go to 0 immediately, with no done pulse afterwards.
  - A new start after release produces a correct product at full latency.
